// File: rtl/tlc_sensor_cond.sv
// Detector conditioning for the traffic-light controller: 2-flop sync, debounce, request hold until grant.
// Optional stuck-sensor detection is enabled with `define TLC_STUCK_DET_EN.
module tlc_sensor_cond #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 255
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic FS_RAW,
  input  logic HS_RAW,
  input  logic FLEFT,
  input  logic HLEFT,
  output logic FS,
  output logic HS,
  output logic FS_STUCK,
  output logic HS_STUCK
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PEND, SERVE} state_t;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 15) begin : g_bad_deb
    $error("DEB_CYCLES out of range 2..15");
  end
  if (STUCK_CYCLES < 16 || STUCK_CYCLES > 65535) begin : g_bad_stuck
    $error("STUCK_CYCLES out of range 16..65535");
  end

  logic [1:0] raw, grant, req, stuck;

  assign raw   = {HS_RAW, FS_RAW};
  assign grant = {HLEFT, FLEFT};
  assign FS       = req[0];
  assign HS       = req[1];
  assign FS_STUCK = stuck[0];
  assign HS_STUCK = stuck[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             req_q;
    logic             stuck_d;

    // A disagreement must persist DEB_CYCLES samples before deb follows it.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_MAX) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

`ifdef TLC_STUCK_DET_EN
    localparam int SC_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STUCK_CYCLES);

    logic [SC_W-1:0] scnt_q, scnt_d;
    logic            stuck_q;

    always_comb begin
      scnt_d = '0;
      if (deb_q) begin
        scnt_d = (scnt_q == SC_MAX) ? scnt_q : scnt_q + 1'b1;
      end
    end

    assign stuck_d = (scnt_d == SC_MAX);

    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
        scnt_q  <= '0;
        stuck_q <= 1'b0;
      end else begin
        scnt_q  <= scnt_d;
        stuck_q <= stuck_d;
      end
    end

    assign stuck[c] = stuck_q;
`else
    assign stuck_d  = 1'b0;
    assign stuck[c] = 1'b0;
`endif

    // A pending request is kept even if the vehicle leaves; it is served once.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (deb_q) state_d = PEND;
        PEND:    if (grant[c]) state_d = SERVE;
        SERVE:   if (!grant[c]) state_d = deb_q ? PEND : IDLE;
        default: state_d = IDLE;
      endcase
      if (stuck_d) state_d = IDLE;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
        state_q <= IDLE;
        req_q   <= 1'b0;
      end else begin
        sync1_q <= raw[c];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
        req_q   <= (state_d == PEND);
      end
    end

    assign req[c] = req_q;
  end

endmodule
